// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI responder.
package spi_pkg;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam int         BYTE_W    = 8;
    localparam int         CNT_W     = $clog2(BYTE_W);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input with one-clock rise/fall pulses
// derived from its two oldest stages.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
    assign o_fall = ~r_sync[SYNC_STAGES-2] & r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder: oversamples an external master on the system clock, delivers each byte
// with its DC flag and shifts a host-supplied byte back on MISO.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int CLK_FRE     = 50,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              spi_dc,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              send_en,
    input  logic [BYTE_W-1:0] send_data,
    output logic              send_busy,
    output logic [BYTE_W-1:0] recv_data,
    output logic              recv_dc,
    output logic              recv_valid,
    output logic              tx_underrun,
    output logic              frame_err
);

    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sck_rise;
    logic w_sck_fall;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_dc_sync;
    logic                   w_mosi_s;
    logic                   w_dc_s;

    spi_state_t r_state;
    spi_state_t w_state_next;

    logic              w_byte_start;
    logic              w_cs_end;
    logic              w_bit_rise;
    logic              w_bit_fall;
    logic [BYTE_W-1:0] w_tx_next;

    logic [CNT_W-1:0]  r_bit_cnt;
    logic [BYTE_W-2:0] r_rx_shift;
    logic [BYTE_W-2:0] r_tx_shift;
    logic [BYTE_W-1:0] r_tx_buf;
    logic              r_tx_pending;

    logic              r_miso;
    logic              r_miso_oe;
    logic [BYTE_W-1:0] r_recv_data;
    logic              r_recv_dc;
    logic              r_recv_valid;
    logic              r_tx_underrun;
    logic              r_frame_err;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_cs_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (spi_cs),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sck_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (spi_sck),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    // MOSI/DC only need a level, but use the same depth so they line up with the SCK edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mosi_sync <= '0;
            r_dc_sync   <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], spi_dc};
        end
    end

    assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
    assign w_dc_s    = r_dc_sync[SYNC_STAGES-1];
    assign w_tx_next = r_tx_pending ? r_tx_buf : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // CS deassertion wins over any SCK edge arriving in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_byte_start = 1'b0;
        w_cs_end     = 1'b0;
        w_bit_rise   = 1'b0;
        w_bit_fall   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_ACTIVE;
                    w_byte_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    w_cs_end     = 1'b1;
                end else begin
                    w_bit_rise = w_sck_rise;
                    if (w_sck_fall) begin
                        if (r_bit_cnt == '0) begin
                            w_byte_start = 1'b1;
                        end else begin
                            w_bit_fall = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt     <= '0;
            r_tx_pending  <= 1'b0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_recv_data   <= '0;
            r_recv_dc     <= 1'b0;
            r_recv_valid  <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_recv_valid  <= 1'b0;
            r_tx_underrun <= w_byte_start & ~r_tx_pending;
            r_frame_err   <= w_cs_end & (r_bit_cnt != '0);

            if (w_cs_end || (w_byte_start && r_state == ST_IDLE)) begin
                r_bit_cnt <= '0;
            end else if (w_bit_rise) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end

            if (w_cs_end) begin
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else if (w_byte_start) begin
                r_miso <= w_tx_next[BYTE_W-1];
                if (r_state == ST_IDLE) begin
                    r_miso_oe <= 1'b1;
                end
            end else if (w_bit_fall) begin
                r_miso <= r_tx_shift[BYTE_W-2];
            end

            if (w_bit_rise && r_bit_cnt == CNT_W'(BYTE_W - 1)) begin
                r_recv_data  <= {r_rx_shift, w_mosi_s};
                r_recv_dc    <= w_dc_s;
                r_recv_valid <= 1'b1;
            end

            // A host write coinciding with a load that empties the buffer is dropped: busy was high.
            if (w_byte_start && r_tx_pending) begin
                r_tx_pending <= 1'b0;
            end else if (send_en && !r_tx_pending) begin
                r_tx_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (send_en && !r_tx_pending) begin
            r_tx_buf <= send_data;
        end
        if (w_byte_start) begin
            r_tx_shift <= w_tx_next[BYTE_W-2:0];
        end else if (w_bit_fall) begin
            r_tx_shift <= {r_tx_shift[BYTE_W-3:0], 1'b0};
        end
        if (w_bit_rise) begin
            r_rx_shift <= {r_rx_shift[BYTE_W-3:0], w_mosi_s};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (SYNC_STAGES >= 2 && CLK_FRE >= 8 && SPI_MODE0 == 2'b00)
                else $error("spi_slave_rx: unsupported parameter set");
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign send_busy   = r_tx_pending;
    assign recv_data   = r_recv_data;
    assign recv_dc     = r_recv_dc;
    assign recv_valid  = r_recv_valid;
    assign tx_underrun = r_tx_underrun;
    assign frame_err   = r_frame_err;

endmodule
